// File: rtl/ex_seq_divider.sv
// ex_seq_divider: radix-2 restoring DIV/DIVU/REM/REMU unit for the execute stage.
// Ports: clk, rst (sync, active-high), start, op[1:0], word, in1, in2, flush,
//        div_stall (comb), valid (1-cycle pulse), result (registered).
module ex_seq_divider #(
   parameter int BUS_WIDTH    = 64,
   parameter bit WORD_MODE_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic                 word,
   input  logic [BUS_WIDTH-1:0] in1,
   input  logic [BUS_WIDTH-1:0] in2,
   input  logic                 flush,
   output logic                 div_stall,
   output logic                 valid,
   output logic [BUS_WIDTH-1:0] result
);

   localparam int W  = BUS_WIDTH;
   localparam int CW = $clog2(W + 1);

   localparam logic [W-1:0] MIN_F = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MIN_W = {W{1'b1}} << 31;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_dvs;
   logic          r_is_rem;
   logic          r_word;
   logic          r_sa;
   logic          r_sb;
   logic [W-1:0]  r_result;
   logic          r_valid;

   // operand conditioning at the start edge
   logic          w_word;
   logic          w_sgn;
   logic          w_is_rem;
   logic [W-1:0]  w_a;
   logic [W-1:0]  w_b;
   logic [W-1:0]  w_a_ext;
   logic          w_sa;
   logic          w_sb;
   logic [W-1:0]  w_ma;
   logic [W-1:0]  w_mb;
   logic          w_div0;
   logic          w_ovf;
   logic [W-1:0]  w_spec;
   logic [CW-1:0] w_n;

   // one restoring step
   logic [W:0]    w_sh;
   logic          w_ge;
   logic [W-1:0]  w_diff;
   logic [W-1:0]  w_rem_n;
   logic [W-1:0]  w_quo_n;
   logic [W-1:0]  w_raw;
   logic          w_neg;
   logic [W-1:0]  w_fix;
   logic [W-1:0]  w_final;

   always_comb begin
      w_word   = word & WORD_MODE_EN;
      w_sgn    = ~op[0];
      w_is_rem = op[1];

      w_a = in1;
      w_b = in2;
      if (w_word) begin
         if (w_sgn) begin
            w_a = W'($signed(in1[31:0]));
            w_b = W'($signed(in2[31:0]));
         end else begin
            w_a = W'(in1[31:0]);
            w_b = W'(in2[31:0]);
         end
      end

      // remainder of x/0 is the dividend sign-extended even for REMUW
      w_a_ext = w_word ? W'($signed(in1[31:0])) : in1;

      w_sa = w_sgn & w_a[W-1];
      w_sb = w_sgn & w_b[W-1];
      w_ma = w_sa ? -w_a : w_a;
      w_mb = w_sb ? -w_b : w_b;

      w_div0 = (w_b == '0);
      w_ovf  = w_sgn && (&w_b) &&
               (w_a == (w_word ? MIN_W : MIN_F));

      if (w_div0)
         w_spec = w_is_rem ? w_a_ext : '1;
      else
         w_spec = w_is_rem ? '0 : w_a;

      w_n = w_word ? CW'(32) : CW'(W);
   end

   always_comb begin
      w_sh    = {r_rem, r_quo[W-1]};
      w_ge    = (w_sh >= {1'b0, r_dvs});
      // exact when w_ge: the difference is below 2^W
      w_diff  = w_sh[W-1:0] - r_dvs;
      w_rem_n = w_ge ? w_diff : w_sh[W-1:0];
      w_quo_n = {r_quo[W-2:0], w_ge};

      w_raw   = r_is_rem ? w_rem_n : w_quo_n;
      w_neg   = r_is_rem ? r_sa : (r_sa ^ r_sb);
      w_fix   = w_neg ? -w_raw : w_raw;
      w_final = r_word ? W'($signed(w_fix[31:0])) : w_fix;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_is_rem <= 1'b0;
         r_word   <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (start) begin
                  r_is_rem <= w_is_rem;
                  r_word   <= w_word;
                  r_sa     <= w_sa;
                  r_sb     <= w_sb;
                  r_cnt    <= w_n;
                  if (w_div0 || w_ovf) begin
                     r_result <= w_spec;
                     r_valid  <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_rem   <= '0;
                     // word magnitudes sit in the top half so 32 shifts
                     // consume exactly their 32 significant bits
                     r_quo   <= w_word ? (w_ma << 32) : w_ma;
                     r_dvs   <= w_mb;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_result <= w_final;
                  r_valid  <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign div_stall = ((r_state == S_IDLE) && start && !flush) ||
                      (r_state == S_CALC);
   assign valid     = r_valid;
   assign result    = r_result;

endmodule

// File: tb/tb_ex_seq_divider.sv
// tb_ex_seq_divider: directed self-checking bench for ex_seq_divider.
// Ports: drives every DUT port; inputs change on the falling edge.
module tb_ex_seq_divider;

   localparam logic [1:0] DIV  = 2'b00;
   localparam logic [1:0] DIVU = 2'b01;
   localparam logic [1:0] REM  = 2'b10;
   localparam logic [1:0] REMU = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic        word;
   logic [63:0] in1;
   logic [63:0] in2;
   logic        flush;
   logic        div_stall;
   logic        valid;
   logic [63:0] result;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ex_seq_divider #(
      .BUS_WIDTH    (64),
      .WORD_MODE_EN (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .word      (word),
      .in1       (in1),
      .in2       (in2),
      .flush     (flush),
      .div_stall (div_stall),
      .valid     (valid),
      .result    (result)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
   endtask

   // start in cycle 0, then look for valid in cycles 1..100
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_res,
                         input int exp_lat);
      int lat;
      int bad;
      lat = -1;
      bad = 0;
      @(negedge clk);
      op = o; word = w; in1 = a; in2 = b; start = 1'b1;
      #1;
      chk({tag, ".stall_c0"}, 64'(div_stall), 64'd1);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         if (valid) begin
            lat = c;
            break;
         end
         if (!div_stall) bad++;
         @(negedge clk);
      end
      chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, ".result"}, result, exp_res);
      chk({tag, ".stall_done"}, 64'(div_stall), 64'd0);
      chk({tag, ".stall_gaps"}, 64'(bad), 64'd0);
      @(negedge clk);
      chk({tag, ".valid_1cyc"}, 64'(valid), 64'd0);
   endtask

   initial begin
      int lat;
      int nval;
      logic [63:0] last;

      rst = 1'b1; start = 1'b0; op = DIV; word = 1'b0;
      in1 = '0; in2 = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.valid", 64'(valid), 64'd0);
      chk("reset.result", result, 64'd0);
      chk("reset.stall", 64'(div_stall), 64'd0);
      rst = 1'b0;

      run_op("div100_7", DIV, 1'b0, 64'd100, 64'd7, 64'd14, 65);
      run_op("rem_m7_2", REM, 1'b0, -64'sd7, 64'd2, '1, 65);
      run_op("remu_m7_2", REMU, 1'b0, -64'sd7, 64'd2, 64'd1, 65);
      run_op("div_7_m2", DIV, 1'b0, 64'd7, -64'sd2, -64'sd3, 65);
      run_op("rem_7_m2", REM, 1'b0, 64'd7, -64'sd2, 64'd1, 65);
      run_op("div_by0", DIV, 1'b0, 64'd5, 64'd0, '1, 1);
      run_op("rem_by0", REM, 1'b0, 64'd5, 64'd0, 64'd5, 1);
      run_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
             64'h8000_0000_0000_0000, 1);
      run_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, '1,
             64'd0, 1);
      run_op("divw", DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2,
             64'hFFFF_FFFF_C000_0000, 33);
      run_op("divuw", DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd16,
             64'h0000_0000_0FFF_FFFF, 33);
      last = 64'h0000_0000_0FFF_FFFF;

      // flush in cycle 10
      @(negedge clk);
      op = DIV; word = 1'b0; in1 = 64'd100; in2 = 64'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      nval = 0;
      if (valid) nval++;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush.idle_stall", 64'(div_stall), 64'd0);
      chk("flush.result", result, last);
      for (int c = 0; c < 80; c++) begin
         if (valid) nval++;
         @(negedge clk);
      end
      chk("flush.no_valid", 64'(nval), 64'd0);

      // second start during CALC is dropped
      @(negedge clk);
      op = DIV; word = 1'b0; in1 = 64'd100; in2 = 64'd7; start = 1'b1;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 5) begin
            start = 1'b1; op = REM; in1 = 64'd9; in2 = 64'd4;
         end
         if (c == 6) start = 1'b0;
         if (valid) begin
            lat = c;
            break;
         end
      end
      chk("busy.latency", 64'(lat), 64'd65);
      chk("busy.result", result, 64'd14);
      nval = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (valid) nval++;
      end
      chk("busy.no_extra", 64'(nval), 64'd0);

      // reset in cycle 20
      @(negedge clk);
      op = DIV; word = 1'b0; in1 = 64'd1000; in2 = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst.valid", 64'(valid), 64'd0);
      chk("rst.result", result, 64'd0);
      chk("rst.stall", 64'(div_stall), 64'd0);
      rst = 1'b0;

      run_op("after_rst", DIV, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
